// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax packer / unpacker pair: result geometry,
// unpacker state encoding and a counter-width helper.
package softmax_pkg;

    localparam int RESULT_W = 128;
    localparam int WORD_W   = 16;
    localparam int WORDS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } unpack_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            return 1;
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/softmax_unpack.sv
// Consumer of the packer's 128-bit result interface. Latches one result,
// emits it as WORDS words (low word first) into a downstream FIFO honouring
// full, then acknowledges upstream with a single-cycle done pulse.
module softmax_unpack
    import softmax_pkg::*;
#(
    parameter int WORDS  = softmax_pkg::WORDS,
    parameter int WORD_W = softmax_pkg::WORD_W,
    parameter int GAP    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid,
    input  logic [WORDS*WORD_W-1:0]   data_in,
    output logic                      done,
    input  logic                      full,
    output logic                      wr_en,
    output logic [WORD_W-1:0]         wr_data,
    output logic                      busy
);

    localparam int DATA_W = WORDS * WORD_W;
    localparam int WCNT_W = clog2_min1(WORDS);
    localparam int GCNT_W = clog2_min1(GAP + 1);

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
    localparam logic [GCNT_W-1:0] GAP_LOAD  = GCNT_W'(GAP);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_ONE  = GCNT_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_ZERO = GCNT_W'(0);
    localparam logic [WORD_W-1:0] WORD_ZERO = WORD_W'(0);

    unpack_state_e       state_r;
    unpack_state_e       state_s;
    logic [DATA_W-1:0]   shift_r;
    logic [WCNT_W-1:0]   wcnt_r;
    logic [GCNT_W-1:0]   gcnt_r;
    logic                done_r;
    logic                load_s;
    logic                wr_en_s;

    // Next-state decode plus the load and write strobes.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        wr_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    load_s  = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!full && (gcnt_r == GCNT_ZERO)) begin
                    wr_en_s = 1'b1;
                    if (wcnt_r == LAST_WORD) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register: captured on acceptance, drained one word per write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            shift_r <= data_in;
        end else if (wr_en_s) begin
            shift_r <= {WORD_ZERO, shift_r[DATA_W-1:WORD_W]};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Word counter: cleared on acceptance, advanced on each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r <= {WCNT_W{1'b0}};
        end else if (load_s) begin
            wcnt_r <= {WCNT_W{1'b0}};
        end else if (wr_en_s) begin
            wcnt_r <= wcnt_r + WCNT_ONE;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Gap counter: reloaded by a write, then runs down even while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_r <= GCNT_ZERO;
        end else if (wr_en_s) begin
            gcnt_r <= GAP_LOAD;
        end else if (gcnt_r != GCNT_ZERO) begin
            gcnt_r <= gcnt_r - GCNT_ONE;
        end else begin
            gcnt_r <= gcnt_r;
        end
    end

    // Acknowledge pulse, high exactly for the ACK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_s == ST_ACK);
        end
    end

    assign done    = done_r;
    assign wr_en   = wr_en_s;
    assign wr_data = shift_r[WORD_W-1:0];
    assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_softmax_unpack.sv
// Scoreboard bench for softmax_unpack: one instance with GAP=1 and one with
// GAP=0. Expected words are derived from each result's bit layout and queued
// at issue time; a negedge monitor pops and compares on every write strobe.
module tb_softmax_unpack;

    localparam int NW = 8;
    localparam int WW = 16;

    logic              clk;
    logic              rst_n;
    logic [1:0]        valid;
    logic [127:0]      data_in [2];
    logic [1:0]        full;
    logic [1:0]        done_o;
    logic [1:0]        wr_en_o;
    logic [1:0]        busy_o;
    logic [WW-1:0]     wr_data_o [2];

    logic [WW-1:0]     exp_q [2][$];
    int                wr_cnt [2];
    int                res_words [2];
    logic              prev_wr [2];
    int                n_checks;
    int                n_fail;

    // Instance 0: back-to-back writes allowed.
    softmax_unpack #(.WORDS(NW), .WORD_W(WW), .GAP(0)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .valid(valid[0]), .data_in(data_in[0]),
        .done(done_o[0]), .full(full[0]), .wr_en(wr_en_o[0]),
        .wr_data(wr_data_o[0]), .busy(busy_o[0])
    );

    // Instance 1: one idle cycle after each write.
    softmax_unpack #(.WORDS(NW), .WORD_W(WW), .GAP(1)) u_gap1 (
        .clk(clk), .rst_n(rst_n), .valid(valid[1]), .data_in(data_in[1]),
        .done(done_o[1]), .full(full[1]), .wr_en(wr_en_o[1]),
        .wr_data(wr_data_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, expected %0h", name, inst, act, exp);
        end
    endtask

    // Monitor: compares every written word against the scoreboard queue.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                res_words[i] = 0;
                prev_wr[i]   = 1'b0;
            end else begin
                if (wr_en_o[i]) begin
                    check("write_while_full", i, full[i], 1'b0);
                    if (exp_q[i].size() == 0) begin
                        check("unexpected_write", i, wr_data_o[i], 128'hX);
                    end else begin
                        check("wr_data", i, wr_data_o[i], exp_q[i].pop_front());
                    end
                    if (i == 1) begin
                        check("gap_respected", i, prev_wr[i], 1'b0);
                    end
                    wr_cnt[i]++;
                    res_words[i]++;
                end
                if (done_o[i]) begin
                    check("words_before_done", i, res_words[i], NW);
                    check("done_after_last_write", i, prev_wr[i], 1'b1);
                    check("busy_during_done", i, busy_o[i], 1'b1);
                    res_words[i] = 0;
                end
                prev_wr[i] = wr_en_o[i];
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one result; full_mode 0=never full, 1=full in cycles 3..6, 2=random.
    task automatic run_result(input int inst, input logic [127:0] d,
                              input int exp_lat, input int full_mode);
        int c;
        bit seen;
        @(posedge clk);
        #1;
        valid[inst]   = 1'b1;
        data_in[inst] = d;
        for (int k = 0; k < NW; k++) begin
            exp_q[inst].push_back(d[k*WW +: WW]);
        end
        seen = 1'b0;
        c = 0;
        while (!seen && c < 300) begin
            @(posedge clk);
            #1;
            c++;
            if (full_mode == 1) begin
                full[inst] = (c >= 3 && c <= 6);
            end else if (full_mode == 2) begin
                full[inst] = ($urandom_range(0, 2) == 0);
            end else begin
                full[inst] = 1'b0;
            end
            if (done_o[inst]) begin
                seen = 1'b1;
            end
        end
        valid[inst] = 1'b0;
        full[inst]  = 1'b0;
        if (!seen) begin
            check("done_timeout", inst, 1'b0, 1'b1);
        end else if (exp_lat > 0) begin
            check("done_latency", inst, c, exp_lat);
        end
    endtask

    initial begin
        int base;
        bit hit;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; res_words[i] = 0; prev_wr[i] = 1'b0;
            data_in[i] = 128'h0;
        end
        valid = 2'b00;
        full  = 2'b00;
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < 2; i++) begin
            check("reset_done", i, done_o[i], 1'b0);
            check("reset_wr_en", i, wr_en_o[i], 1'b0);
            check("reset_busy", i, busy_o[i], 1'b0);
            check("reset_wr_data", i, wr_data_o[i], 16'h0);
        end
        #19;
        rst_n = 1'b1;

        // Basic order and latency, GAP=1.
        run_result(1, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 16, 0);
        @(posedge clk);
        #1;
        check("busy_after_ack", 1, busy_o[1], 1'b0);

        // Backpressure: four stalled cycles delay done by four.
        run_result(1, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 20, 1);

        // Back-to-back: second result issued the cycle after done.
        base = wr_cnt[1];
        run_result(1, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 16, 0);
        run_result(1, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_0001, 0, 0);
        @(posedge clk);
        #1;
        check("back_to_back_writes", 1, wr_cnt[1] - base, 2 * NW);

        // GAP=0: consecutive writes, done at cycle 9.
        run_result(0, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 9, 0);
        run_result(0, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 13, 1);

        // Reset after three writes.
        base = wr_cnt[1];
        @(posedge clk);
        #1;
        valid[1]   = 1'b1;
        data_in[1] = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
        for (int k = 0; k < NW; k++) begin
            exp_q[1].push_back(data_in[1][k*WW +: WW]);
        end
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (wr_cnt[1] - base >= 3) begin
                hit = 1'b1;
            end
        end
        rst_n    = 1'b0;
        valid[1] = 1'b0;
        #1;
        check("rst_mid_hit", 1, hit, 1'b1);
        check("rst_mid_done", 1, done_o[1], 1'b0);
        check("rst_mid_wr_en", 1, wr_en_o[1], 1'b0);
        check("rst_mid_busy", 1, busy_o[1], 1'b0);
        check("rst_mid_wr_data", 1, wr_data_o[1], 16'h0);
        check("rst_mid_written", 1, wr_cnt[1] - base, 3);
        exp_q[1].delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = wr_cnt[1];
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_reset", 1, busy_o[1], 1'b0);
        check("no_write_after_reset", 1, wr_cnt[1] - base, 0);
        run_result(1, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 16, 0);

        // Randomized results with random backpressure on both instances.
        for (int r = 0; r < 8; r++) begin
            run_result(r % 2, rand128(), 0, 2);
        end
        for (int r = 0; r < 4; r++) begin
            run_result(1, rand128(), 16, 0);
            run_result(0, rand128(), 9, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 0, exp_q[0].size(), 0);
        check("queue_drained", 1, exp_q[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
